// File: rtl/exp_sched_pkg.sv
// Shared types and constants for the exponent-engine scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT = 1023;

  // All-ones error result for a W-bit bus (caller truncates to W bits).
  function automatic logic [63:0] result_err(input int w);
    return ~(64'hFFFF_FFFF_FFFF_FFFF << w);
  endfunction

endpackage

// File: rtl/exp_sched_rr_arb.sv
// Round-robin picker: one-hot grant to the first requester after last_grant, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  // Scan from last_grant+1 around the ring; the first pending request wins.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(last_grant) + i) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/exp_sched.sv
// Shares one iterative exponent engine between NREQ requesters, round-robin.
// Latency: accept T -> eng_start T+1, rsp D+1 after eng_done D; bypass/illegal rsp at T+1.
// Backpressure: one job in flight; no request is accepted until the response handshake completes.
module exp_sched
  import exp_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_base,
  input  logic [NREQ*W-1:0] req_limit,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_err,
  output logic              eng_start,
  output logic [W-1:0]      eng_base,
  output logic [W-1:0]      eng_limit,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_result,
  output logic              busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW  = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]    RES_ERR   = W'(result_err(W));
  localparam logic [WDW-1:0]  WD_LAST   = WDW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] LAST_INIT = IDXW'(NREQ - 1);

  state_t            state, state_d;
  logic [IDXW-1:0]   last_grant, grant_idx, arb_idx;
  logic [NREQ-1:0]   arb_gnt, grant_oh;
  logic              arb_any;
  logic [WDW-1:0]    wdog;
  logic [W-1:0]      result_q;
  logic              err_q;
  logic [W-1:0]      sel_base, sel_limit;
  logic              take, rsp_take, base_illegal, base_bypass;

  rr_arb #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .idx        (arb_idx),
    .any        (arb_any)
  );

  // One-hot AND-OR mux of the winning requester's operands.
  always_comb begin
    sel_base  = '0;
    sel_limit = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_base  = req_base[i*W +: W];
        sel_limit = req_limit[i*W +: W];
      end
    end
  end

  assign take         = (state == IDLE) && arb_any;
  assign rsp_take     = (state == RESP) && |(rsp_ready & grant_oh);
  // base 0/1 never reaches any limit above it, so the engine would spin forever.
  assign base_illegal = (sel_base <= W'(1));
  assign base_bypass  = (sel_base >= sel_limit);

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d   = state;
    req_ready = '0;
    rsp_valid = '0;
    eng_start = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = arb_gnt;
        if (take) begin
          state_d = (base_illegal || base_bypass) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (eng_done || (wdog == WD_LAST)) state_d = RESP;
      end
      RESP: begin
        rsp_valid = grant_oh;
        if (rsp_take) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Job datapath: operand latch, watchdog, result capture and fairness pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= LAST_INIT;
      grant_idx  <= '0;
      grant_oh   <= '0;
      eng_base   <= '0;
      eng_limit  <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      wdog       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            grant_idx <= arb_idx;
            grant_oh  <= arb_gnt;
            eng_base  <= sel_base;
            eng_limit <= sel_limit;
            if (base_illegal) begin
              result_q <= RES_ERR;
              err_q    <= 1'b1;
            end else if (base_bypass) begin
              result_q <= '0;
              err_q    <= 1'b0;
            end
          end
        end
        ISSUE: wdog <= '0;
        WAIT: begin
          // A done coinciding with expiry is still a valid completion.
          if (eng_done) begin
            result_q <= eng_result;
            err_q    <= 1'b0;
          end else if (wdog == WD_LAST) begin
            result_q <= RES_ERR;
            err_q    <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (rsp_take) last_grant <= grant_idx;
        end
        default: ;
      endcase
    end
  end

  assign rsp_result = result_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_exp_sched.sv
// Self-checking bench for exp_sched with a behavioural engine and a response scoreboard.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low.
module tb_exp_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [63:0] req_base = '0;
  logic [63:0] req_limit = '0;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready = '0;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic        eng_start;
  logic [15:0] eng_base, eng_limit;
  logic        eng_done = 1'b0;
  logic [15:0] eng_result = '0;
  logic        busy;

  exp_sched #(.NREQ(4), .W(16), .TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_limit(req_limit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_base(eng_base), .eng_limit(eng_limit),
    .eng_done(eng_done), .eng_result(eng_result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   start_cnt = 0;
  int   eng_lat = 2;
  bit   eng_auto = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: smallest k with base^(k+1) >= limit.
  function automatic logic [15:0] model_exp(input logic [15:0] b, input logic [15:0] l);
    longint p;
    int k;
    p = longint'(b);
    k = 0;
    while (p < longint'(l)) begin
      p = p * longint'(b);
      k++;
    end
    return 16'(k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] b, input logic [15:0] l);
    req_base[i*16 +: 16]  = b;
    req_limit[i*16 +: 16] = l;
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid != 4'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Behavioural engine: answers each start pulse after eng_lat cycles.
  initial begin
    logic [15:0] b, l;
    forever begin
      @(posedge clk);
      #1;
      if (eng_start === 1'b1) begin
        start_cnt++;
        if (eng_auto) begin
          b = eng_base;
          l = eng_limit;
          repeat (eng_lat - 1) begin
            @(posedge clk);
            #1;
          end
          eng_result = model_exp(b, l);
          eng_done   = 1'b1;
          done_cyc   = cyc;
          @(posedge clk);
          #1;
          eng_done = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_err, eng_start, eng_base, eng_limit, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rr=%b rv=%b res=%h err=%b st=%b eb=%h el=%h busy=%b want all 0",
               req_ready, rsp_valid, rsp_result, rsp_err, eng_start, eng_base, eng_limit, busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    eng_auto = 1'b0;
    set_op(0, 16'd3, 16'd50);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    checks++;
    if (eng_start !== 1'b1) begin errors++; $display("FAIL rmw_start got %b want 1", eng_start); end
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0) begin
      errors++; $display("FAIL rmw_reset got busy=%b rv=%b want 0 0", busy, rsp_valid);
    end
    tick();
    rst = 1'b0;
    eng_done = 1'b1;
    eng_result = 16'd3;
    tick();
    eng_done = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0 || eng_start !== 1'b0) begin
      errors++; $display("FAIL rmw_stale_done got rv=%b busy=%b st=%b want 0 0 0", rsp_valid, busy, eng_start);
    end
    set_op(1, 16'd3, 16'd10);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmw_fresh_ready got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (eng_start !== 1'b1 || eng_base !== 16'd3) begin
      errors++; $display("FAIL rmw_fresh_start got st=%b base=%0d want 1 3", eng_start, eng_base);
    end
    tick();
    eng_done = 1'b1;
    eng_result = 16'd2;
    tick();
    eng_done = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_result !== 16'd2 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL rmw_fresh_rsp got rv=%b res=%0d err=%b want 0010 2 0", rsp_valid, rsp_result, rsp_err);
    end
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = 4'b0000;
  endtask

  task automatic test_normal();
    bit ok;
    eng_auto = 1'b1;
    eng_lat  = 7;
    set_op(0, 16'd2, 16'd100);
    req_valid = 4'b0001;
    sb.push_back('{idx: 0, res: 16'd6, err: 1'b0});
    tick();
    req_valid = 4'b0000;
    checks++;
    if (eng_start !== 1'b1 || eng_base !== 16'd2 || eng_limit !== 16'd100) begin
      errors++; $display("FAIL normal_issue got st=%b base=%0d lim=%0d want 1 2 100", eng_start, eng_base, eng_limit);
    end
    wait_rsp(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL normal_timeout got no rsp_valid want rsp within 50 cycles"); end
    checks++;
    if (cyc !== done_cyc + 1) begin errors++; $display("FAIL normal_latency got cyc %0d want %0d", cyc, done_cyc + 1); end
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== (4'b1 << e.idx) || rsp_result !== e.res || rsp_err !== e.err) begin
      errors++; $display("FAIL normal_rsp got rv=%b res=%0d err=%b want idx%0d %0d %b", rsp_valid, rsp_result, rsp_err, e.idx, e.res, e.err);
    end
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = 4'b0000;
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL normal_release got rv=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    bit ok;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eng_lat = 3;
    for (int i = 0; i < 4; i++) set_op(i, 16'd3, 16'd10);
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    #1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (req_ready !== (4'b1 << (j % 4))) begin
        errors++; $display("FAIL rr_grant%0d got %b want %b", j, req_ready, 4'b1 << (j % 4));
      end
      sb.push_back('{idx: j % 4, res: 16'd2, err: 1'b0});
      tick();
      if (j == 4) req_valid = 4'b0000;
      wait_rsp(50, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_timeout%0d got no rsp_valid want rsp", j); end
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== (4'b1 << e.idx) || rsp_result !== e.res || rsp_err !== e.err) begin
        errors++; $display("FAIL rr_rsp%0d got rv=%b res=%0d err=%b want idx%0d %0d %b", j, rsp_valid, rsp_result, rsp_err, e.idx, e.res, e.err);
      end
      tick();
    end
    rsp_ready = 4'b0000;
  endtask

  task automatic test_illegal_bypass();
    int s0;
    s0 = start_cnt;
    set_op(2, 16'd1, 16'd9);
    req_valid = 4'b0100;
    sb.push_back('{idx: 2, res: 16'hFFFF, err: 1'b1});
    tick();
    req_valid = 4'b0000;
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== (4'b1 << e.idx) || rsp_result !== e.res || rsp_err !== e.err) begin
      errors++; $display("FAIL illegal_rsp got rv=%b res=%h err=%b want idx%0d %h %b", rsp_valid, rsp_result, rsp_err, e.idx, e.res, e.err);
    end
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = 4'b0000;
    set_op(2, 16'd20, 16'd5);
    req_valid = 4'b0100;
    sb.push_back('{idx: 2, res: 16'd0, err: 1'b0});
    tick();
    req_valid = 4'b0000;
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== (4'b1 << e.idx) || rsp_result !== e.res || rsp_err !== e.err) begin
      errors++; $display("FAIL bypass_rsp got rv=%b res=%h err=%b want idx%0d %h %b", rsp_valid, rsp_result, rsp_err, e.idx, e.res, e.err);
    end
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = 4'b0000;
    tick();
    checks++;
    if (start_cnt !== s0) begin errors++; $display("FAIL no_start got %0d pulses want %0d", start_cnt, s0); end
  endtask

  task automatic test_timeout();
    bit ok;
    int entry;
    eng_auto = 1'b0;
    set_op(3, 16'd3, 16'd50);
    req_valid = 4'b1000;
    sb.push_back('{idx: 3, res: 16'hFFFF, err: 1'b1});
    tick();
    req_valid = 4'b0000;
    tick();
    entry = cyc;
    wait_rsp(1100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_none got no rsp_valid want rsp"); end
    checks++;
    if (cyc - entry !== 1023) begin errors++; $display("FAIL timeout_latency got %0d want 1023", cyc - entry); end
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== (4'b1 << e.idx) || rsp_result !== e.res || rsp_err !== e.err) begin
      errors++; $display("FAIL timeout_rsp got rv=%b res=%h err=%b want idx%0d %h %b", rsp_valid, rsp_result, rsp_err, e.idx, e.res, e.err);
    end
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = 4'b0000;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) set_op(i, 16'd20, 16'd5);
    req_valid = 4'b1111;
    rsp_ready = 4'b0000;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_first got %b want 0001", req_ready); end
    sb.push_back('{idx: 0, res: 16'd0, err: 1'b0});
    tick();
    for (int c = 0; c < 6; c++) begin
      if (c == 5) rsp_ready = 4'b1110;
      #1;
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_result !== 16'd0 || rsp_err !== 1'b0 || req_ready !== 4'b0) begin
        errors++; $display("FAIL b2b_stall%0d got rv=%b res=%h err=%b rr=%b want 0001 0 0 0000", c, rsp_valid, rsp_result, rsp_err, req_ready);
      end
      tick();
    end
    rsp_ready = 4'b0001;
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== (4'b1 << e.idx) || rsp_result !== e.res || rsp_err !== e.err) begin
      errors++; $display("FAIL b2b_rsp got rv=%b res=%h err=%b want idx%0d %h %b", rsp_valid, rsp_result, rsp_err, e.idx, e.res, e.err);
    end
    tick();
    rsp_ready = 4'b0000;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_next got %b want 0010", req_ready); end
    sb.push_back('{idx: 1, res: 16'd0, err: 1'b0});
    tick();
    req_valid = 4'b0000;
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== (4'b1 << e.idx) || rsp_result !== e.res || rsp_err !== e.err) begin
      errors++; $display("FAIL b2b_rsp2 got rv=%b res=%h err=%b want idx%0d %h %b", rsp_valid, rsp_result, rsp_err, e.idx, e.res, e.err);
    end
    rsp_ready = 4'b1111;
    tick();
    rsp_ready = 4'b0000;
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL b2b_drain got busy=%b sb=%0d want 0 0", busy, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_normal();
    test_round_robin();
    test_illegal_bypass();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no completion want finish before 500000");
    $fatal(1, "bench did not complete");
  end

endmodule
